data_skid: RTL and testbench
============================

// Module: data_skid
// PURPOSE
//  Valid/ready register slice with a two-entry skid buffer. Both directions are registered:
//  - in_ready_o comes from a flop.
//  - out_data_o and out_valid_o come from flops.
//  Breaks long ready chains where a data_hs forward slice leaves ready combinational.
//  Sits between stream stages. Throughput is one beat per cycle, with no loss or duplication.
// PARAMETERS
//  WIDTH      32  payload width in bits
//  CNT_WIDTH  16  stall-counter width; used only when DATA_SKID_STAT_EN is defined
// PORTS
//  clk_i        in   1          clock; all logic on posedge
//  rst_i        in   1          asynchronous, active-high reset
//  in_data_i    in   WIDTH      upstream payload
//  in_valid_i   in   1          upstream valid
//  in_ready_o   out  1          registered ready to upstream
//  out_data_o   out  WIDTH      registered payload to downstream
//  out_valid_o  out  1          registered valid to downstream
//  out_ready_i  in   1          downstream ready
//  stall_cnt_o  out  CNT_WIDTH  stall counter; port exists only with DATA_SKID_STAT_EN
// BEHAVIOUR
//  - Clocking/reset: one clock, clk_i. Reset is async active-high on rst_i: always_ff @(posedge clk_i or posedge rst_i).
//  - Reset values:
//    - state = EMPTY.
//    - in_ready_o = 0, out_valid_o = 0.
//    - out_data_o = 0, skid register = 0, stall_cnt_o = 0.
//  - Ready after reset: in_ready_o rises at the first clk_i edge after rst_i deasserts.
//  - Handshakes: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
//    out_data_o/out_valid_o stay stable while out_valid_o=1 and out_ready_i=0.
//  - States (data_skid_pkg::state_t):
//    - EMPTY: out_valid=0.
//    - BUSY: out_valid=1, skid empty.
//    - FULL: out_valid=1, skid holds one beat.
//  - Transitions:
//    - EMPTY, in_fire -> BUSY; out_data <= in_data_i.
//    - BUSY, in_fire & out_fire -> BUSY; out_data <= in_data_i.
//    - BUSY, in_fire & !out_fire -> FULL; skid <= in_data_i.
//    - BUSY, !in_fire & out_fire -> EMPTY.
//    - FULL, out_fire -> BUSY; out_data <= skid. No input is accepted in FULL.
//    - Any other case: hold state and data.
//  - in_ready_o next value = (next_state != FULL). out_valid_o = (state != EMPTY).
//  - Latency: accepted beat appears on out_data_o the cycle after in_fire, when the slice was EMPTY or BUSY with out_fire.
//  - Ordering: strictly FIFO. The skid beat always drains before any newer beat.
//  - Combinational paths: none from any input to any output.
//  - Reset mid-operation: buffered beats are discarded; outputs take reset values immediately (async).
//  - in_valid_i while in_ready_o=0 is ignored; upstream must hold the beat.
// CONFIGURATION
//  Macro: DATA_SKID_STAT_EN.
//  - Defined:
//    - Adds stall_cnt_o.
//    - Increments by 1 on each cycle with out_valid_o=1 & out_ready_i=0.
//    - Saturates at 2**CNT_WIDTH-1. Cleared only by reset.
//  - Undefined:
//    - Port and counter are absent.
//    - CNT_WIDTH is ignored.
//    - Datapath behaviour is identical.
// STRUCTURE
//  - data_skid_pkg:
//    - typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t.
//  - Sub-module data_skid_reg:
//    - WIDTH-bit enabled register, async active-high reset to 0.
//    - Instantiated twice: output register and skid register.
//  - FSM and ready flop live in data_skid.
// TESTING
//  1. Reset: rst_i=1 mid-transfer with skid FULL -> out_valid_o=0, in_ready_o=0, out_data_o=0 at once;
//     in_ready_o=1 one cycle after release.
//  2. Stream: out_ready_i=1, in_valid_i=1 with data 1..8 -> out_data_o 1..8 in order, one cycle later, no bubbles.
//  3. Backpressure: with out_ready_i=0, accept 32'hA5A5A5A5 then 32'h5A5A5A5A ->
//     - FULL, in_ready_o=0 next cycle.
//     - Set out_ready_i=1: A5A5A5A5 then 5A5A5A5A.
//  4. Concurrent: in BUSY with in_fire & out_fire on data 7 -> stays BUSY, out_data_o=7 next cycle.
//  5. Random: 1000 beats, random in_valid_i/out_ready_i -> scoreboard exact, no loss or duplication.
//     Output is stable whenever stalled.
//  6. Stats (macro on): 5 stalled cycles -> stall_cnt_o=5.
//     With CNT_WIDTH=2 and 6 stalls -> saturates at 3.

Source files
------------

// File: rtl/data_skid_pkg.sv
// Shared types for the data_skid register slice.
//
// Contents:
//   state_t      - slice occupancy state (EMPTY / BUSY / FULL)
//   state_holds  - number of beats held by the slice in a given state
package data_skid_pkg;

  // EMPTY: nothing buffered, out_valid low.
  // BUSY : one beat on the output register, skid register empty.
  // FULL : output register and skid register both hold a beat.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Occupancy of the slice for a given state.
  function automatic int unsigned state_holds(state_t s);
    case (s)
      BUSY:    return 1;
      FULL:    return 2;
      default: return 0;
    endcase
  endfunction

endpackage : data_skid_pkg

// File: rtl/data_skid_reg.sv
// Enabled WIDTH-bit register with asynchronous active-high reset to zero.
// Used by data_skid for both the output register and the skid register.
//
// Ports:
//   clk_i  - clock, posedge
//   rst_i  - asynchronous active-high reset, clears q_o
//   en_i   - load enable
//   d_i    - data to load
//   q_o    - registered data
module data_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : data_skid_reg

// File: rtl/data_skid.sv
// Valid/ready register slice with a two-entry skid buffer. Every output is driven
// directly from a flop, so there is no combinational path from any input to any
// output; this breaks long ready chains between stream stages while sustaining one
// beat per cycle.
//
// Optional feature (macro DATA_SKID_STAT_EN): adds stall_cnt_o, a saturating count of
// cycles with out_valid_o=1 and out_ready_i=0, cleared only by reset.
//
// Ports:
//   clk_i        - clock, posedge
//   rst_i        - asynchronous active-high reset
//   in_data_i    - upstream payload
//   in_valid_i   - upstream valid
//   in_ready_o   - registered ready to upstream
//   out_data_o   - registered payload to downstream
//   out_valid_o  - registered valid to downstream
//   out_ready_i  - downstream ready
//   stall_cnt_o  - stall counter (only with DATA_SKID_STAT_EN)
module data_skid
  import data_skid_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
`ifdef DATA_SKID_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   valid_q, valid_d;

  logic   in_fire, out_fire;
  logic   out_en, out_sel_skid, skid_en;

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = in_valid_i & ready_q;
  assign out_fire = valid_q & out_ready_i;

  // Next-state and register-load decode. FULL never accepts input because
  // ready_q is low whenever the slice is FULL.
  always_comb begin
    state_d      = state_q;
    out_en       = 1'b0;
    out_sel_skid = 1'b0;
    skid_en      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          out_en  = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          out_en = 1'b1;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind the current one.
          state_d = FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          // Skid beat is older than anything upstream, so it drains first.
          state_d      = BUSY;
          out_en       = 1'b1;
          out_sel_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign out_d = out_sel_skid ? skid_q : in_data_i;

  // Ready and valid are re-registered from the next state rather than decoded
  // from state_q, keeping both handshake outputs straight off flops.
  assign ready_d = (state_d != FULL);
  assign valid_d = (state_d != EMPTY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  data_skid_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (out_en),
    .d_i   (out_d),
    .q_o   (out_q)
  );

  data_skid_reg #(
    .WIDTH (WIDTH)
  ) u_skid_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (skid_en),
    .d_i   (in_data_i),
    .q_o   (skid_q)
  );

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = out_q;

`ifdef DATA_SKID_STAT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  // Counter width only matters when statistics are built in.
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule : data_skid

// File: tb/tb_data_skid.sv
module tb_data_skid;

  localparam int unsigned WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [WIDTH-1:0] in_data_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

`ifdef DATA_SKID_STAT_EN
  logic [15:0]      stall_cnt_o;
  logic [1:0]       stall_cnt2;
  logic             in_ready2, out_valid2;
  logic [WIDTH-1:0] out_data2;
`endif

  data_skid #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef DATA_SKID_STAT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

`ifdef DATA_SKID_STAT_EN
  // Narrow-counter instance sharing the same stimulus, for saturation.
  data_skid #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (2)
  ) dut2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready2),
    .out_data_o  (out_data2),
    .out_valid_o (out_valid2),
    .out_ready_i (out_ready_i),
    .stall_cnt_o (stall_cnt2)
  );
`endif

  // Reset, release on a falling edge, and wait for ready to come up.
  task automatic apply_reset;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_data_i   = '0;
    rst_i       = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== '0) begin
      failures++;
      $display("FAIL reset_values: valid=%b ready=%b data=%h, want 0 0 0",
               out_valid_o, in_ready_o, out_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready_o);
    end
    @(negedge clk_i);
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b want 1", in_ready_o);
    end
    // Fill to FULL with downstream stalled.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h11;
    @(negedge clk_i);
    in_data_i = 32'h22;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'h11) begin
      failures++;
      $display("FAIL full_before_reset: ready=%b valid=%b data=%h, want 0 1 00000011",
               in_ready_o, out_valid_o, out_data_o);
    end
    // Asynchronous reset mid-cycle, away from any edge.
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b ready=%b data=%h, want 0 0 0",
               out_valid_o, in_ready_o, out_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset: ready=%b valid=%b, want 1 0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_stream;
    apply_reset();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'(i - 1) || in_ready_o !== 1'b1) begin
          failures++;
          $display("FAIL stream_beat%0d: valid=%b ready=%b data=%h, want 1 1 %h",
                   i - 1, out_valid_o, in_ready_o, out_data_o, 32'(i - 1));
        end
      end
      in_valid_i = (i <= 8);
      in_data_i  = 32'(i);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hA5A5A5A5;
    @(negedge clk_i);
    in_data_i = 32'h5A5A5A5A;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bp_full: ready=%b valid=%b data=%h, want 0 1 a5a5a5a5",
               in_ready_o, out_valid_o, out_data_o);
    end
    @(negedge clk_i);
    checks++;
    if (out_data_o !== 32'hA5A5A5A5 || out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: valid=%b data=%h, want 1 a5a5a5a5", out_valid_o, out_data_o);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (out_data_o !== 32'h5A5A5A5A || out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: valid=%b ready=%b data=%h, want 1 1 5a5a5a5a",
               out_valid_o, in_ready_o, out_data_o);
    end
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_concurrent;
    apply_reset();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'd3;
    @(negedge clk_i);
    in_data_i   = 32'd7;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'd7 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL concurrent: valid=%b ready=%b data=%h, want 1 1 00000007",
               out_valid_o, in_ready_o, out_data_o);
    end
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL concurrent_drain: valid=%b want 0", out_valid_o);
    end
  endtask

  // Reference model: an ordered queue of accepted beats plus an occupancy count.
  // The slice holds at most two beats, and accepts whenever it is not holding two.
  task automatic test_random;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] prev_data;
    int   pops = 0;
    int   cycles = 0;
    int   occ = 0;
    logic stall_prev = 1'b0;
    logic pending = 1'b0;
    logic in_fire, out_fire;
    apply_reset();
    while (pops < 1000 && cycles < 20000) begin
      cycles++;
      checks++;
      if (out_valid_o !== (occ != 0)) begin
        failures++;
        $display("FAIL rand_valid cyc%0d: got %b want %b", cycles, out_valid_o, occ != 0);
      end
      checks++;
      if (in_ready_o !== (occ != 2)) begin
        failures++;
        $display("FAIL rand_ready cyc%0d: got %b want %b", cycles, in_ready_o, occ != 2);
      end
      if (occ != 0) begin
        checks++;
        if (out_data_o !== sb[0]) begin
          failures++;
          $display("FAIL rand_data cyc%0d: got %h want %h", cycles, out_data_o, sb[0]);
        end
      end
      if (stall_prev) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
          failures++;
          $display("FAIL rand_stable cyc%0d: valid=%b data=%h want 1 %h",
                   cycles, out_valid_o, out_data_o, prev_data);
        end
      end
      // Upstream holds an unaccepted beat; otherwise offer something new.
      if (!pending) begin
        in_valid_i = ($urandom_range(0, 3) != 0);
        in_data_i  = $urandom;
      end
      out_ready_i = ($urandom_range(0, 2) != 0);
      in_fire     = in_valid_i && (occ != 2);
      out_fire    = (occ != 0) && out_ready_i;
      pending     = in_valid_i && !in_fire;
      stall_prev  = (occ != 0) && !out_ready_i;
      prev_data   = out_data_o;
      @(negedge clk_i);
      if (out_fire) begin
        void'(sb.pop_front());
        pops++;
      end
      if (in_fire) sb.push_back(in_data_i);
      occ = occ + int'(in_fire) - int'(out_fire);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    checks++;
    if (pops < 1000) begin
      failures++;
      $display("FAIL rand_budget: popped %0d beats, want 1000", pops);
    end
  endtask

`ifdef DATA_SKID_STAT_EN
  task automatic test_stats;
    apply_reset();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hC0DE;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if (stall_cnt_o !== 16'd5 || stall_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL stats_5: cnt=%0d cnt2=%0d, want 5 3", stall_cnt_o, stall_cnt2);
    end
    @(negedge clk_i);
    checks++;
    if (stall_cnt_o !== 16'd6 || stall_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL stats_6: cnt=%0d cnt2=%0d, want 6 3", stall_cnt_o, stall_cnt2);
    end
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (stall_cnt_o !== 16'd6) begin
      failures++;
      $display("FAIL stats_hold: cnt=%0d want 6", stall_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_concurrent();
    test_random();
`ifdef DATA_SKID_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_skid
